srio_swrite_pack_logic: RTL and testbench

- Transmit-side counterpart of the SWRITE unpacker; sits directly upstream of the SRIO core's TX HELLO port.
- Buffers one payload packet from an AXIS source (ad9361 branch data tagged by TDEST), maps TDEST to an SRIO address and counts the beats.
- Then emits an Ftype 6 (SWRITE) HELLO header word followed by the buffered payload.

---
 rtl/srio_swrite_pack_logic.sv | 177 +++++++++++++++++
 tb/tb_srio_swrite_pack_logic.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_swrite_pack_logic.sv
// SRIO SWRITE packer: buffers one AXIS payload packet, then emits a HELLO
// Ftype 6 header word followed by the payload. Optional TID counter: SWRITE_PACK_TID_EN.
`timescale 1ns/1ps
module srio_swrite_pack_logic #(
  parameter int         MAX_BEATS = 32,
  parameter logic [1:0] PRIO      = 2'd1
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic [3:0]  S_AXIS_TDEST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic [31:0] cmd,
  input  logic [31:0] addr_0,
  input  logic [31:0] addr_1,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(MAX_BEATS);
  localparam int CW = AW + 1;
  localparam int SW = CW + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DROP,
    ST_HDR,
    ST_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   drop_q, drop_d;
  logic          wr_en;
  logic          tid_inc;
  logic [7:0]    tid_w;
  logic [SW-1:0] bytes_m1;
  logic [7:0]    size_w;
  logic [15:0]   drop_inc;
  logic          unused_cmd;

  logic [63:0]   pay_mem [MAX_BEATS];

  assign unused_cmd = ^cmd[31:2];
  assign bytes_m1   = {cnt_q, 3'b000} - SW'(1);
  assign size_w     = 8'(bytes_m1);
  assign drop_inc   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
  assign drop_cnt   = drop_q;

`ifdef SWRITE_PACK_TID_EN
  logic [7:0] tid_q;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET)   tid_q <= 8'h00;
    else if (cmd[1])   tid_q <= 8'h00;
    else if (tid_inc)  tid_q <= tid_q + 8'd1;
  end

  assign tid_w = tid_q;
`else
  logic unused_tid;

  assign unused_tid = tid_inc;
  assign tid_w      = 8'h00;
`endif

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    addr_d        = addr_q;
    drop_d        = drop_q;
    wr_en         = 1'b0;
    tid_inc       = 1'b0;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = 64'h0;
    M_AXIS_TLAST  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd[0]) state_d = ST_FILL;
      end

      ST_FILL: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID) begin
          // Unmapped branch: first beat is discarded and the rest swallowed in DROP.
          if (cnt_q == '0 && S_AXIS_TDEST > 4'd1) begin
            if (S_AXIS_TLAST) drop_d  = drop_inc;
            else              state_d = ST_DROP;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '0) addr_d = S_AXIS_TDEST[0] ? addr_1 : addr_0;
            if (S_AXIS_TLAST || cnt_q == CW'(MAX_BEATS - 1)) state_d = ST_HDR;
          end
        end
      end

      ST_DROP: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && S_AXIS_TLAST) begin
          drop_d  = drop_inc;
          state_d = ST_FILL;
        end
      end

      ST_HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = {tid_w, 4'h6, 4'h0, 1'b0, PRIO, 1'b0, size_w, 4'h0, addr_q};
        if (M_AXIS_TREADY) begin
          tid_inc = 1'b1;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = pay_mem[rd_q[AW-1:0]];
        M_AXIS_TLAST  = (rd_q == cnt_q - CW'(1));
        if (M_AXIS_TREADY) begin
          if (M_AXIS_TLAST) begin
            cnt_d   = '0;
            rd_d    = '0;
            state_d = ST_FILL;
          end else begin
            rd_d = rd_q + CW'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Soft reset overrides everything; a packet in flight is abandoned.
    if (cmd[1]) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      rd_d    = '0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      addr_q  <= 32'h0;
      drop_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: the payload buffer has no reset; every entry is written in FILL
  // before DRAIN can read it, so stale contents are never visible.
  always_ff @(posedge AXIS_ACLK) begin
    if (wr_en) pay_mem[cnt_q[AW-1:0]] <= S_AXIS_TDATA;
  end

endmodule

// File: tb/tb_srio_swrite_pack_logic.sv
// Self-checking bench for srio_swrite_pack_logic: directed vector table,
// random traffic against a packet-level reference model, soft and async reset cases.
`timescale 1ns/1ps
module tb_srio_swrite_pack_logic;

  localparam int         MAX_BEATS = 32;
  localparam logic [1:0] PRIO      = 2'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = 64'h0;
  logic        s_tlast = 1'b0;
  logic [3:0]  s_tdest = 4'h0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic [31:0] cmd = 32'h0;
  logic [31:0] addr_0 = 32'h0000_1000;
  logic [31:0] addr_1 = 32'hA5A5_0000;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  srio_swrite_pack_logic #(.MAX_BEATS(MAX_BEATS), .PRIO(PRIO)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TREADY(s_tready),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TLAST (s_tlast),
    .S_AXIS_TDEST (s_tdest),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TREADY(m_tready),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TLAST (m_tlast),
    .cmd          (cmd),
    .addr_0       (addr_0),
    .addr_1       (addr_1),
    .drop_cnt     (drop_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [3:0]  dest;
    int          n;
    logic [63:0] hdr;
    int          words;
    logic [15:0] drop;
    int          idx2;
    logic [63:0] hdr2;
  } vec_t;

  beat_t       src_q[$];
  word_t       exp_q[$];
  word_t       got_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_tid = 0;
  logic [15:0] exp_drop = 16'h0;
  logic        bp_en = 1'b0;
  logic        gap_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = 64'h0;
  logic        prev_last = 1'b0;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] tid_f(input int k);
`ifdef SWRITE_PACK_TID_EN
    return 8'(k);
`else
    return 8'(k) & 8'h00;
`endif
  endfunction

  function automatic logic [63:0] hdr_word(input int tid, input int len, input logic [31:0] a);
    return {tid_f(tid), 4'h6, 4'h0, 1'b0, PRIO, 1'b0, 8'(len * 8 - 1), 4'h0, a};
  endfunction

  // Reference model: whole packets in, header + payload words out.
  task automatic add_packet(input logic [3:0] dest, input int n);
    beat_t       b;
    word_t       w;
    logic [63:0] d[$];
    int          pos;
    int          len;
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == n - 1);
      b.dest = dest;
      src_q.push_back(b);
      d.push_back(b.data);
    end
    if (dest > 4'd1) begin
      if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    end else begin
      pos = 0;
      while (pos < n) begin
        len    = (n - pos > MAX_BEATS) ? MAX_BEATS : n - pos;
        w.data = hdr_word(exp_tid, len, (dest == 4'd0) ? addr_0 : addr_1);
        w.last = 1'b0;
        exp_q.push_back(w);
        exp_tid = (exp_tid + 1) % 256;
        for (int j = 0; j < len; j++) begin
          w.data = d[pos + j];
          w.last = (j == len - 1);
          exp_q.push_back(w);
        end
        pos += len;
      end
    end
  endtask

  task automatic step();
    logic        s_rdy;
    logic        m_vld;
    logic        m_lst;
    logic [63:0] m_dat;
    word_t       w;
    if (src_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      s_tvalid = 1'b1;
      s_tdata  = src_q[0].data;
      s_tlast  = src_q[0].last;
      s_tdest  = src_q[0].dest;
    end else begin
      s_tvalid = 1'b0;
    end
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    s_rdy = s_tready;
    m_vld = m_tvalid;
    m_dat = m_tdata;
    m_lst = m_tlast;
    if (prev_stall) begin
      check("stall_valid", 64'(m_vld), 64'd1);
      check("stall_data", m_dat, prev_data);
      check("stall_last", 64'(m_lst), 64'(prev_last));
    end
    prev_stall = m_vld && !m_tready;
    prev_data  = m_dat;
    prev_last  = m_lst;
    @(posedge clk);
    #1;
    if (s_tvalid && s_rdy) void'(src_q.pop_front());
    if (m_vld && m_tready) begin
      w.data = m_dat;
      w.last = m_lst;
      got_q.push_back(w);
    end
  endtask

  task automatic run_quiet(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      step();
      n++;
      if (src_q.size() != 0 || m_tvalid) quiet = 0;
      else quiet++;
    end
    check("run_completes", 64'(quiet >= 4), 64'd1);
  endtask

  task automatic compare_out(input string tag);
    int n;
    check($sformatf("%s_len", tag), 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
      check($sformatf("%s_last[%0d]", tag, i), 64'(got_q[i].last), 64'(exp_q[i].last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int tid0;
    int n;

    vecs[0] = '{4'd0,  4,  64'h0060_21F0_0000_1000, 5,  16'd0, 0,  64'h0};
    vecs[1] = '{4'd1,  1,  64'h0060_2070_A5A5_0000, 2,  16'd0, 0,  64'h0};
    vecs[2] = '{4'd5,  3,  64'h0,                   0,  16'd1, 0,  64'h0};
    vecs[3] = '{4'd0,  2,  64'h0060_20F0_0000_1000, 3,  16'd1, 0,  64'h0};
    vecs[4] = '{4'd0,  40, 64'h0060_2FF0_0000_1000, 42, 16'd1, 33, 64'h0060_23F0_0000_1000};
    vecs[5] = '{4'd1,  32, 64'h0060_2FF0_A5A5_0000, 33, 16'd1, 0,  64'h0};
    vecs[6] = '{4'd7,  1,  64'h0,                   0,  16'd2, 0,  64'h0};
    vecs[7] = '{4'd15, 40, 64'h0,                   0,  16'd3, 0,  64'h0};
    vecs[8] = '{4'd0,  33, 64'h0060_2FF0_0000_1000, 35, 16'd3, 33, 64'h0060_2070_0000_1000};

    // Reset state
    #12;
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", m_tdata, 64'h0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("idle_tready", 64'(s_tready), 64'd0);
    cmd = 32'h1;
    step();
    cmd = 32'h0;
    check("fill_tready", 64'(s_tready), 64'd1);

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      tid0 = exp_tid;
      add_packet(vecs[v].dest, vecs[v].n);
      run_quiet(2000);
      check($sformatf("v%0d_words", v), 64'(got_q.size()), 64'(vecs[v].words));
      if (vecs[v].words > 0 && got_q.size() > 0)
        check($sformatf("v%0d_hdr", v), got_q[0].data, vecs[v].hdr | {tid_f(tid0), 56'h0});
      if (vecs[v].idx2 > 0 && got_q.size() > vecs[v].idx2)
        check($sformatf("v%0d_hdr2", v), got_q[vecs[v].idx2].data,
              vecs[v].hdr2 | {tid_f(tid0 + 1), 56'h0});
      check($sformatf("v%0d_drop", v), 64'(drop_cnt), 64'(vecs[v].drop));
      compare_out($sformatf("v%0d", v));
    end

    // Random traffic with backpressure; soft reset first so TIDs restart at 0
    cmd = 32'h2;
    step();
    cmd = 32'h1;
    step();
    cmd = 32'h0;
    exp_tid = 0;
    bp_en   = 1'b1;
    gap_en  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      add_packet(4'($urandom_range(0, 1)), $urandom_range(1, MAX_BEATS));
      if (k % 10 == 5) add_packet(4'($urandom_range(2, 15)), $urandom_range(1, 40));
    end
    run_quiet(40000);
    compare_out("rand");
    check("rand_drop", 64'(drop_cnt), 64'(exp_drop));
    bp_en  = 1'b0;
    gap_en = 1'b0;

    // Soft reset during DRAIN beat 2 of 8 (cmd[0] also set: cmd[1] must win)
    add_packet(4'd0, 8);
    exp_q.delete();
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      step();
      n++;
    end
    check("cmd1_reach_drain2", 64'(got_q.size()), 64'd3);
    cmd = 32'h3;
    step();
    cmd = 32'h0;
    check("cmd1_tvalid", 64'(m_tvalid), 64'd0);
    check("cmd1_tready", 64'(s_tready), 64'd0);
    step();
    check("cmd1_idle_tready", 64'(s_tready), 64'd0);
    check("cmd1_idle_tvalid", 64'(m_tvalid), 64'd0);
    got_q.delete();
    src_q.delete();
    exp_tid = 0;
    cmd = 32'h1;
    step();
    cmd = 32'h0;
    add_packet(4'd1, 3);
    run_quiet(2000);
    compare_out("after_cmd1");

    // Asynchronous reset in the middle of FILL
    add_packet(4'd0, 6);
    exp_q.delete();
    step();
    step();
    step();
    check("mid_fill_tready", 64'(s_tready), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tready", 64'(s_tready), 64'd0);
    check("arst_tvalid", 64'(m_tvalid), 64'd0);
    check("arst_tdata", m_tdata, 64'h0);
    check("arst_tlast", 64'(m_tlast), 64'd0);
    check("arst_drop", 64'(drop_cnt), 64'd0);
    src_q.delete();
    got_q.delete();
    s_tvalid   = 1'b0;
    exp_tid    = 0;
    exp_drop   = 16'h0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd = 32'h1;
    step();
    cmd = 32'h0;
    add_packet(4'd1, 2);
    run_quiet(2000);
    compare_out("after_arst");
    check("after_arst_drop", 64'(drop_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
